// File: rtl/nrisc_pkg.sv
// Shared types for the NRISC shared-memory arbiter: FSM states, core id and access op.
package nrisc_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t ACC  = 2'd1;
    localparam state_t RESP = 2'd2;

    typedef logic core_id_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the requester that was not granted last wins.
module rr_pick2
    import nrisc_pkg::*;
(
    input  logic [1:0] req,
    input  core_id_t   last,
    output core_id_t   grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        if (&req) begin
            grant = ~last;
        end else begin
            grant = core_id_t'(req[1]);
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Two-core arbiter for the single-port shared data RAM: round-robin grant, then an
// IDLE -> ACC (-> RESP) sequence that drives the RAM and returns done/rdata to the winner.
module shared_mem_arbiter
    import nrisc_pkg::*;
#(
    parameter int unsigned TAM      = 16,
    parameter int unsigned LDataMem = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load0,
    input  logic                load1,
    input  logic                write0,
    input  logic                write1,
    input  logic [TAM-1:0]      addr0,
    input  logic [TAM-1:0]      addr1,
    input  logic [TAM-1:0]      wdata0,
    input  logic [TAM-1:0]      wdata1,
    output logic [TAM-1:0]      rdata0,
    output logic [TAM-1:0]      rdata1,
    output logic                done0,
    output logic                done1,
    output logic                stall0,
    output logic                stall1,
    output logic [LDataMem-1:0] mem_addr,
    output logic [TAM-1:0]      mem_wdata,
    output logic                mem_we,
    output logic                mem_re,
    input  logic [TAM-1:0]      mem_rdata
);

    state_t               state_q, state_d;
    core_id_t             last_q, last_d;
    core_id_t             id_q, id_d;
    op_t                  op_q, op_d;
    logic [LDataMem-1:0]  addr_d;
    logic [TAM-1:0]       wdata_d;
    logic                 we_d, re_d, done0_d, done1_d;
    logic [TAM-1:0]       rdata0_d, rdata1_d;
    core_id_t             pick_id;
    logic                 pick_valid;

    // Upper address bits are deliberately discarded (address wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr0[TAM-1:LDataMem], addr1[TAM-1:LDataMem]};

    // Masking with done keeps the finishing core from being re-granted in its done cycle.
    assign stall0 = (load0 | write0) & ~done0;
    assign stall1 = (load1 | write1) & ~done1;

    rr_pick2 u_pick (
        .req   ({stall1, stall0}),
        .last  (last_q),
        .grant (pick_id),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            op_q      <= OP_READ;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            id_q      <= id_d;
            op_q      <= op_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_we    <= we_d;
            mem_re    <= re_d;
            done0     <= done0_d;
            done1     <= done1_d;
            rdata0    <= rdata0_d;
            rdata1    <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        op_d     = op_q;
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
        we_d     = 1'b0;
        re_d     = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        rdata0_d = rdata0;
        rdata1_d = rdata1;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    id_d    = pick_id;
                    last_d  = pick_id;
                    addr_d  = pick_id ? addr1[LDataMem-1:0] : addr0[LDataMem-1:0];
                    wdata_d = pick_id ? wdata1 : wdata0;
                    op_d    = (pick_id ? write1 : write0) ? OP_WRITE : OP_READ;
                    // RAM strobes are registered, so they are set up on the grant edge.
                    we_d    = (op_d == OP_WRITE);
                    re_d    = (op_d == OP_READ);
                    state_d = ACC;
                end
            end
            ACC: begin
                if (op_q == OP_WRITE) begin
                    done0_d = (id_q == 1'b0);
                    done1_d = (id_q == 1'b1);
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (id_q) begin
                    rdata1_d = mem_rdata;
                end else begin
                    rdata0_d = mem_rdata;
                end
                done0_d = (id_q == 1'b0);
                done1_d = (id_q == 1'b1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter: directed and random requests checked each cycle
// against a transaction-timeline model (grant order, fixed latencies, reference memory).
module tb_shared_mem_arbiter;

    localparam int unsigned TAM = 16;
    localparam int unsigned LDM = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load0 = 1'b0, load1 = 1'b0, write0 = 1'b0, write1 = 1'b0;
    logic [TAM-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic [TAM-1:0] rdata0, rdata1;
    logic           done0, done1, stall0, stall1;
    logic [LDM-1:0] mem_addr;
    logic [TAM-1:0] mem_wdata;
    logic           mem_we, mem_re;
    logic [TAM-1:0] mem_rdata = '0;

    shared_mem_arbiter #(.TAM(TAM), .LDataMem(LDM)) dut (
        .clk(clk), .rst(rst),
        .load0(load0), .load1(load1), .write0(write0), .write1(write1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .rdata0(rdata0), .rdata1(rdata1), .done0(done0), .done1(done1),
        .stall0(stall0), .stall1(stall1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency.
    logic [TAM-1:0] ram [0:255] = '{default: '0};
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // Reference model state: pending requests per core and the one access in flight.
    int             t;
    bit             req_act [2];
    int             req_kind [2];          // 0 load, 1 write, 2 load+write
    logic [TAM-1:0] req_addr [2];
    logic [TAM-1:0] req_wdata [2];
    logic [TAM-1:0] ref_mem [0:255] = '{default: '0};
    bit             busy;
    int             cur;
    bit             cur_wr;
    logic [7:0]     cur_a;
    logic [TAM-1:0] cur_d;
    int             acc_at, done_at, last_g;
    logic [7:0]     addr_hold;
    logic [TAM-1:0] exp_rdata [2];
    bit             done_prev [2];
    bit             auto_mode, alt_check;
    int             rate, prev_done_core, served;
    int             n_vec, n_err;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic drive();
        load0  = req_act[0] && (req_kind[0] != 1);
        write0 = req_act[0] && (req_kind[0] != 0);
        load1  = req_act[1] && (req_kind[1] != 1);
        write1 = req_act[1] && (req_kind[1] != 0);
        addr0  = req_addr[0];
        addr1  = req_addr[1];
        wdata0 = req_wdata[0];
        wdata1 = req_wdata[1];
    endtask

    task automatic set_req(input int c, input int kind, input logic [15:0] a, input logic [15:0] d);
        req_act[c]   = 1'b1;
        req_kind[c]  = kind;
        req_addr[c]  = a;
        req_wdata[c] = d;
        drive();
    endtask

    task automatic model_reset();
        busy      = 1'b0;
        last_g    = 1;
        addr_hold = '0;
        for (int c = 0; c < 2; c++) begin
            exp_rdata[c] = '0;
            done_prev[c] = 1'b0;
            req_act[c]   = 1'b0;
        end
        drive();
    endtask

    // One clock cycle: drive at posedge+1, model and compare at negedge.
    task automatic step();
        bit ed [2];
        bit pend [2];
        bit ewe, ere;
        int w, dc;
        for (int c = 0; c < 2; c++) if (done_prev[c]) req_act[c] = 1'b0;
        if (auto_mode) begin
            for (int c = 0; c < 2; c++) begin
                if (!req_act[c] && ($urandom_range(99) < 32'(rate)))
                    set_req(c, int'($urandom_range(2)),
                            16'({8'($urandom_range(255)), 8'($urandom_range(15))}),
                            16'($urandom_range(16'hFFFF)));
            end
        end
        drive();
        @(negedge clk);
        for (int c = 0; c < 2; c++) ed[c] = busy && (cur == c) && (done_at == t);
        ewe = busy && (acc_at == t) && cur_wr;
        ere = busy && (acc_at == t) && !cur_wr;
        if (ewe) ref_mem[cur_a] = cur_d;
        if (busy && ed[cur] && !cur_wr) exp_rdata[cur] = ref_mem[cur_a];

        check("done0", 16'(done0), 16'(ed[0]));
        check("done1", 16'(done1), 16'(ed[1]));
        check("mem_we", 16'(mem_we), 16'(ewe));
        check("mem_re", 16'(mem_re), 16'(ere));
        check("stall0", 16'(stall0), 16'(req_act[0] && !ed[0]));
        check("stall1", 16'(stall1), 16'(req_act[1] && !ed[1]));
        check("rdata0", rdata0, exp_rdata[0]);
        check("rdata1", rdata1, exp_rdata[1]);
        check("mem_addr", 16'(mem_addr), 16'(addr_hold));
        if (ewe) check("mem_wdata", mem_wdata, cur_d);

        if (alt_check && (done0 ^ done1)) begin
            dc = done1 ? 1 : 0;
            if (prev_done_core >= 0) check("alternate", 16'(dc), 16'(1 - prev_done_core));
            prev_done_core = dc;
        end

        if (busy && (done_at == t)) busy = 1'b0;
        if (!busy) begin
            for (int c = 0; c < 2; c++) pend[c] = req_act[c] && !ed[c];
            if (pend[0] || pend[1]) begin
                w = (pend[0] && pend[1]) ? (1 - last_g) : (pend[1] ? 1 : 0);
                last_g    = w;
                busy      = 1'b1;
                cur       = w;
                cur_wr    = (req_kind[w] != 0);
                cur_a     = req_addr[w][7:0];
                cur_d     = req_wdata[w];
                acc_at    = t + 1;
                done_at   = t + (cur_wr ? 2 : 3);
                addr_hold = cur_a;
                served++;
            end
        end
        for (int c = 0; c < 2; c++) done_prev[c] = ed[c];
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_vec = 0; n_err = 0; t = 0; served = 0;
        auto_mode = 1'b0; alt_check = 1'b0; rate = 0; prev_done_core = -1;
        for (int c = 0; c < 2; c++) begin
            req_kind[c] = 0; req_addr[c] = '0; req_wdata[c] = '0;
        end
        model_reset();
        @(posedge clk);
        #1;
        check("rst_done0", 16'(done0), 16'h0);
        check("rst_done1", 16'(done1), 16'h0);
        check("rst_rdata0", rdata0, 16'h0);
        check("rst_rdata1", rdata1, 16'h0);
        check("rst_mem_we", 16'(mem_we), 16'h0);
        check("rst_mem_re", 16'(mem_re), 16'h0);
        check("rst_mem_addr", 16'(mem_addr), 16'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        rst = 1'b0;

        // Core0 write, then core1 read-back of the same word.
        set_req(0, 1, 16'h0010, 16'hBEEF);
        run(4);
        set_req(1, 0, 16'h0010, 16'h0000);
        run(5);

        // Simultaneous writes straight after reset: core0 first, core1 in done0's cycle.
        do_reset();
        set_req(0, 1, 16'h0020, 16'h1111);
        set_req(1, 1, 16'h0021, 16'h2222);
        run(6);

        // load+write together is a write; upper address bits wrap away.
        set_req(0, 2, 16'h01A5, 16'h1234);
        run(4);
        set_req(1, 0, 16'h00A5, 16'h0000);
        run(5);

        // Both cores requesting continuously: completions must alternate.
        auto_mode = 1'b1; rate = 100; alt_check = 1'b1; prev_done_core = -1; served = 0;
        for (int i = 0; i < 200 && served < 20; i++) step();
        check("served_20", 16'(served >= 20), 16'h1);
        auto_mode = 1'b0;
        run(8);
        alt_check = 1'b0;

        // Random traffic.
        auto_mode = 1'b1; rate = 40;
        run(300);
        auto_mode = 1'b0;
        run(10);

        // Reset in the ACC cycle of a write drops mem_we immediately.
        set_req(1, 1, 16'h0030, 16'hCAFE);
        step();
        check("we_before_rst", 16'(mem_we), 16'h1);
        rst = 1'b1;
        #1;
        check("we_async_drop", 16'(mem_we), 16'h0);
        model_reset();
        step();
        rst = 1'b0;

        // Reset in the RESP cycle of a read: nothing completes, state returns to reset values.
        set_req(1, 0, 16'h0010, 16'h0000);
        run(3);
        set_req(0, 0, 16'h00A5, 16'h0000);
        run(2);
        rst = 1'b1;
        #1;
        check("resp_rst_re", 16'(mem_re), 16'h0);
        check("resp_rst_done0", 16'(done0), 16'h0);
        check("resp_rst_rdata0", rdata0, 16'h0);
        check("resp_rst_rdata1", rdata1, 16'h0);
        model_reset();
        step();
        rst = 1'b0;
        // last_grant is back to 1, so core0 wins the tie.
        set_req(0, 0, 16'h0030, 16'h0000);
        set_req(1, 0, 16'h00A5, 16'h0000);
        run(9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Two-way arbiter that lets both NRISC cores share one single-port shared data RAM. Each core raises a load or write request with address and data; the arbiter serialises them round-robin, drives the RAM port through a three-state sequencer, and returns a completion pulse plus read data. It sits between the cores' shared-region data ports and the shared bank of the data memory.

## Interface
- TAM, 16, data and address word width
- LDataMem, 8, shared RAM address width (2^LDataMem words)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- load0 / load1  in  1  read request from core 0 / 1, held until done
- write0 / write1  in  1  write request from core 0 / 1, held until done
- addr0 / addr1  in  TAM  request address; only [LDataMem-1:0] is used
- wdata0 / wdata1  in  TAM  write data
- rdata0 / rdata1  out  TAM  read data, registered, held until that core's next read completes
- done0 / done1  out  1  one-cycle completion pulse, registered
- stall0 / stall1  out  1  (load_i|write_i) & ~done_i, combinational
- mem_addr  out  LDataMem  RAM address
- mem_wdata  out  TAM  RAM write data
- mem_we  out  1  RAM write enable
- mem_re  out  1  RAM read enable; mem_rdata valid the following cycle
- mem_rdata  in  TAM  RAM read data

## Operation
- States: IDLE, ACC, RESP.
- IDLE: effective request req_i = (load_i|write_i) & ~done_i. No request: stay. Else pick a winner. Latch id, addr[LDataMem-1:0], wdata, and op (write if write_i, else read; write wins if both set). Update last_grant to the winner. Go ACC.
- Winner rule: only one requester wins. If both request, the core ≠ last_grant wins. last_grant resets to 1, so core 0 wins the first tie.
- ACC: drive mem_addr/mem_wdata from the latches.
  - Write: mem_we=1, schedule done for the winner, go IDLE.
  - Read: mem_re=1, go RESP.
- RESP: capture mem_rdata into rdata_<id>, schedule done, go IDLE.
- done_<id> is asserted on the cycle after completion scheduling.
- Masking req_i with done_i prevents the finishing core from being re-granted in its done cycle. The other core may be granted in that cycle.
- mem_we/mem_re are 0 outside ACC. mem_addr/mem_wdata hold their last latched value.
- Request inputs are ignored outside IDLE. Changing addr/wdata after grant has no effect on the current access.

## Timing
- Reset values: state=IDLE, last_grant=1, done0/1=0, rdata0/1=0, mem_we=mem_re=0, mem_addr=0, mem_wdata=0.
- Reset mid-access aborts immediately: mem_we/mem_re drop asynchronously, no done is issued, and the request must be reissued.
- Write latency: request seen at cycle 0 → mem_we at cycle 1 → done at cycle 2.
- Read latency: request at cycle 0 → mem_re at cycle 1 → RESP at cycle 2 → done+rdata at cycle 3.
- Back-to-back from alternating cores: the other core is granted in the done cycle. Sustained throughput is one write per 2 cycles or one read per 3 cycles.
- Starvation bound: with both cores always requesting, no core waits more than one foreign access.
- Address wrap: upper address bits are discarded, so 0x01FF and 0x00FF hit the same word when LDataMem=8.

## Structure
- Shared package nrisc_pkg: state enum {IDLE, ACC, RESP}, core id type (1 bit), op type {OP_READ, OP_WRITE}.
- One sub-module, rr_pick2: combinational 2-way round-robin picker (req[1:0], last → grant id, valid). Keep it reusable for a future 4-core variant.

## Test plan
- Reset, then core0 writes 0xBEEF to 0x10 → mem_we high at cycle 1 with addr 0x10, done0 at cycle 2, stall0 high for cycles 0-1.
- Core1 reads 0x10 after that write → mem_re at cycle 1, rdata1=0xBEEF with done1 at cycle 3, rdata0 unchanged.
- Both cores request a write in the same cycle right after reset → core0 served first, core1 granted in done0's cycle, done1 two cycles later.
- Both cores request continuously for 20 accesses → grants alternate 0,1,0,1…, and no core is ever served twice consecutively while the other waits.
- Core0 sets load and write together with addr 0x1A5, data 0x1234 → treated as a write to 0xA5, mem_re never asserted.
- Assert rst during RESP of a read → mem_re/done stay 0, state=IDLE, rdata0/1=0, last_grant=1 after release.
